// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin N-to-1 write arbiter in front of a shared FIFO.
// Define FIFO_ARB_BURST_LOCK_EN to let one grant run for up to MAX_BURST beats.
module fifo_wr_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ready,
   input  logic                        fifo_full,
   input  logic                        fifo_almost_full,
   output logic                        fifo_wr_en,
   output logic [DATA_WIDTH-1:0]       fifo_din,
   output logic [$clog2(N_REQ)-1:0]    grant_id,
   output logic                        busy,
   output logic [15:0]                 beat_cnt_total,
   output logic                        err_overflow
);

   localparam int GW = $clog2(N_REQ);

`ifdef FIFO_ARB_BURST_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   // Without burst lock every grant is a single beat.
   localparam logic [7:0] BURST_LIM = LOCK_EN ? 8'(MAX_BURST) : 8'd1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   logic [0:0]            r_state;
   logic [GW-1:0]         r_grant_id;
   logic [7:0]            r_burst;
   logic                  r_wr_en;
   logic [DATA_WIDTH-1:0] r_din;
   logic [15:0]           r_total;
   logic                  r_err;

   logic [N_REQ-1:0]      w_ready;
   logic                  w_own_valid;
   logic [DATA_WIDTH-1:0] w_own_data;
   logic                  w_stall;
   logic                  w_accept;
   logic                  w_last;
   logic                  w_found;
   logic [GW-1:0]         w_next_id;
   int                    w_dist;
   int                    w_best_dist;

   assign w_stall  = fifo_almost_full | fifo_full;
   assign w_accept = (r_state == S_GRANT) & w_own_valid & ~w_stall;
   assign w_last   = w_accept & ((r_burst + 8'd1) == BURST_LIM);

   // Round-robin pick: nearest valid requester after the last owner.
   always_comb begin
      w_found     = 1'b0;
      w_next_id   = r_grant_id;
      w_best_dist = N_REQ;
      w_dist      = 0;
      for (int i = 0; i < N_REQ; i++) begin
         if (i > int'(r_grant_id))
            w_dist = i - int'(r_grant_id) - 1;
         else
            w_dist = i + N_REQ - int'(r_grant_id) - 1;
         if (req_valid[i] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_next_id   = GW'(i);
            w_found     = 1'b1;
         end
      end
   end

   // Select the current owner's valid and data beat.
   always_comb begin
      w_own_valid = 1'b0;
      w_own_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_grant_id == GW'(i)) begin
            w_own_valid = req_valid[i];
            w_own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Only the owner sees ready, and only while the FIFO has room.
   always_comb begin
      w_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_ready[i] = (r_state == S_GRANT) &&
                      (r_grant_id == GW'(i)) &&
                      !w_stall;
      end
   end

   // Grant FSM: arbitrate in IDLE, run the burst in GRANT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_grant_id <= GW'(N_REQ - 1);
         r_burst    <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant_id <= w_next_id;
                  r_burst    <= 8'd0;
                  r_state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (!w_own_valid) begin
                  r_state <= S_IDLE;
               end else if (w_accept) begin
                  r_burst <= r_burst + 8'd1;
                  if (w_last)
                     r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Register each accepted beat into the FIFO write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en <= 1'b0;
         r_din   <= '0;
      end else begin
         r_wr_en <= w_accept;
         if (w_accept)
            r_din <= w_own_data;
      end
   end

   // Beat counter and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_total <= 16'd0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept)
            r_total <= r_total + 16'd1;
         if (r_wr_en && fifo_full)
            r_err <= 1'b1;
      end
   end

   assign req_ready      = w_ready;
   assign fifo_wr_en     = r_wr_en;
   assign fifo_din       = r_din;
   assign grant_id       = r_grant_id;
   assign busy           = (r_state == S_GRANT);
   assign beat_cnt_total = r_total;
   assign err_overflow   = r_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized scoreboard bench for fifo_wr_arbiter.
// Expected write order comes from a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int GW = 2;
`ifdef FIFO_ARB_BURST_LOCK_EN
   localparam int LIM = MB;
`else
   localparam int LIM = 1;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            fifo_full;
   logic            fifo_almost_full;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_din;
   logic [GW-1:0]   grant_id;
   logic            busy;
   logic [15:0]     beat_cnt_total;
   logic            err_overflow;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready),
      .fifo_full(fifo_full),
      .fifo_almost_full(fifo_almost_full),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
      .grant_id(grant_id), .busy(busy),
      .beat_cnt_total(beat_cnt_total),
      .err_overflow(err_overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0]    rq [N][$];
   logic [GW+DW-1:0] exp_q [$];
   logic [N-1:0]     acc;
   bit               af_rand;
   bit               full_force;
   bit               sb_en;
   int               af_left;
   int               m_last;
   int               m_total;
   int               cnt [N];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_wr_en"}, fifo_wr_en, 0);
      check({tag, "_din"}, fifo_din, 0);
      check({tag, "_grant_id"}, grant_id, N - 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_total"}, beat_cnt_total, 0);
      check({tag, "_err"}, err_overflow, 0);
      check({tag, "_ready"}, req_ready, 0);
   endtask

   function automatic bit rq_empty();
      for (int i = 0; i < N; i++)
         if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Requester and FIFO-flag driver: a beat stays offered until taken.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++)
         if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (!af_rand) begin
         af_left = 0;
         fifo_almost_full = 1'b0;
      end else if (af_left > 0) begin
         af_left--;
         fifo_almost_full = 1'b1;
      end else begin
         fifo_almost_full = 1'b0;
         if ($urandom_range(0, 5) == 0) af_left = $urandom_range(1, 6);
      end
      fifo_full = full_force;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = (rq[i].size() > 0);
         req_data[i*DW +: DW] = req_valid[i] ? rq[i][0] : '0;
      end
      #1 acc = req_valid & req_ready;
   end

   logic [GW-1:0]    p_gid;
   logic             p_busy;
   logic [N-1:0]     p_valid;
   logic [N-1:0]     er;
   logic [GW+DW-1:0] e;

   // Monitor: scoreboard pops on each FIFO write, plus grant rules.
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         p_gid   = grant_id;
         p_busy  = 1'b0;
         p_valid = '0;
      end else begin
         er = '0;
         if (busy && !fifo_almost_full && !fifo_full) er[grant_id] = 1'b1;
         check("req_ready", req_ready, er);
         if (fifo_wr_en && sb_en) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got din=%0h id=%0d, expected none",
                        fifo_din, grant_id);
            end else begin
               e = exp_q.pop_front();
               check("fifo_din", fifo_din, e[DW-1:0]);
               check("write_owner", grant_id, e[GW+DW-1:DW]);
            end
         end
         if (grant_id !== p_gid) check("idle_gap_before_grant", p_busy, 0);
         if (busy && !p_busy) check("granted_was_valid", p_valid[grant_id], 1);
         p_gid   = grant_id;
         p_busy  = busy;
         p_valid = req_valid;
      end
   end

   // Load all requesters at once; model the write order round-robin.
   task automatic run_round();
      int left [N];
      int pos [N];
      int j;
      int take;
      bit any;
      bit done;
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < cnt[i]; k++) rq[i].push_back(DW'($urandom));
         left[i] = cnt[i];
         pos[i]  = 0;
      end
      any = 1'b1;
      while (any) begin
         j = -1;
         for (int s = 1; s <= N; s++) begin
            if (j < 0 && left[(m_last + s) % N] > 0) j = (m_last + s) % N;
         end
         if (j < 0) begin
            any = 1'b0;
         end else begin
            take = (left[j] < LIM) ? left[j] : LIM;
            for (int t = 0; t < take; t++) begin
               exp_q.push_back({GW'(j), rq[j][pos[j]]});
               pos[j]++;
               left[j]--;
               m_total++;
            end
            m_last = j;
         end
      end
      done = 1'b0;
      for (int c = 0; c < 2000 && !done; c++) begin
         @(posedge clk);
         #2;
         if (rq_empty() && exp_q.size() == 0 && !busy && !fifo_wr_en) done = 1'b1;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL round_timeout: got %0d beats pending, expected 0",
                  exp_q.size());
      end
      check("beat_cnt_total", beat_cnt_total, m_total & 16'hFFFF);
      check("last_owner", grant_id, m_last);
   endtask

   initial begin
      int nw;
      bit found;
      rst_n      = 1'b1;
      req_valid  = '0;
      req_data   = '0;
      fifo_full  = 1'b0;
      fifo_almost_full = 1'b0;
      acc        = '0;
      af_rand    = 1'b0;
      af_left    = 0;
      full_force = 1'b0;
      sb_en      = 1'b1;
      m_last     = N - 1;
      m_total    = 0;
      #2 rst_n = 1'b0;
      #1 check_reset("por");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      cnt = '{3, 0, 0, 0};
      run_round();
      cnt = '{8, 8, 8, 8};
      run_round();

      af_rand = 1'b1;
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < N; i++) cnt[i] = $urandom_range(0, 6);
         if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) cnt[$urandom_range(0, 3)] = 1;
         run_round();
      end
      af_rand = 1'b0;
      check("no_overflow_yet", err_overflow, 0);

      @(posedge clk);
      #2;
      rq[1].push_back(8'hA5);
      exp_q.push_back({GW'(1), 8'hA5});
      m_last = 1;
      m_total++;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(posedge clk);
         #2;
         if (fifo_wr_en) begin
            full_force = 1'b1;
            found = 1'b1;
         end
      end
      if (!found) begin
         n_tests++;
         n_fail++;
         $display("FAIL overflow_write: got no write, expected one");
      end
      @(posedge clk);
      #2;
      full_force = 1'b0;
      check("err_overflow_set", err_overflow, 1);
      repeat (5) @(posedge clk);
      #2;
      check("err_overflow_sticky", err_overflow, 1);
      check("total_after_ovf", beat_cnt_total, m_total & 16'hFFFF);

      sb_en = 1'b0;
      @(posedge clk);
      #2;
      for (int k = 0; k < 6; k++) rq[1].push_back(DW'($urandom));
      rq[3].push_back(8'h3C);
      rq[3].push_back(8'hC3);
      nw = 0;
      for (int c = 0; c < 100 && nw < 2; c++) begin
         @(posedge clk);
         #2;
         if (fifo_wr_en) nw++;
      end
      if (nw < 2) begin
         n_tests++;
         n_fail++;
         $display("FAIL midburst_writes: got %0d, expected 2", nw);
      end
      #1 rst_n = 1'b0;
      #1 check_reset("mid_burst");
      for (int i = 0; i < N; i++) rq[i].delete();
      exp_q.delete();
      acc = '0;
      repeat (2) @(posedge clk);
      #2;
      rst_n   = 1'b1;
      sb_en   = 1'b1;
      m_last  = N - 1;
      m_total = 0;
      repeat (4) @(posedge clk);
      #2;
      check("no_write_after_reset", fifo_wr_en, 0);
      cnt = '{2, 0, 2, 0};
      run_round();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
